// File: rtl/fa_bist_ctrl.sv
// ---------------------------------------------------------------------------
// fa_bist_ctrl
//
// Built-in self-test controller for a single-bit full adder. A run walks all
// eight {a,b,c_in} vectors in ascending order. Each vector is held for
// SETTLE_CYCLES cycles so the adder under test can settle. One further CHECK
// cycle then compares the adder's sum/c_out against a golden full adder
// computed from the registered vector.
//
// Parameters
//   SETTLE_CYCLES  cycles a vector is held before it is sampled (>= 1)
//   ERR_CNT_W      width of err_count; the count saturates at all-ones
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   start            begins a run; only looked at while idle
//   a, b, c_in       registered vector to the adder under test
//                    (vector bit 2, 1, 0 respectively)
//   dut_sum          sum returned by the adder under test
//   dut_c_out        carry-out returned by the adder under test
//   busy             high while vectors are being applied and checked
//   done             one-cycle pulse marking the end of a run
//   pass             last completed run saw no mismatches; held until the
//                    next start
//   err_count        number of mismatching vectors (saturating)
//   first_fail_vec   {a,b,c_in} of the first mismatching vector
//   first_fail_valid first_fail_vec holds a captured vector
// ---------------------------------------------------------------------------
module fa_bist_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  output logic                 c_in,
  input  logic                 dut_sum,
  input  logic                 dut_c_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2:0]           first_fail_vec,
  output logic                 first_fail_valid
);

  // The settle counter runs up to SETTLE_CYCLES on the final settle cycle,
  // so it must be wide enough to hold that value.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [2:0]           vec;
  logic [CNT_W-1:0]     settle_cnt;
  logic                 gold_sum;
  logic                 gold_c_out;
  logic                 mismatch;
  logic [ERR_CNT_W-1:0] err_after;

  assign a    = vec[2];
  assign b    = vec[1];
  assign c_in = vec[0];

  // busy and done are pure decodes of the state register, so they change
  // only on clock edges and drop immediately on reset.
  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);

  // The golden adder works from the registered vector, i.e. from exactly
  // what the adder under test is currently being driven with.
  assign gold_sum   = vec[2] ^ vec[1] ^ vec[0];
  assign gold_c_out = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  assign mismatch   = (dut_sum != gold_sum) || (dut_c_out != gold_c_out);

  // Error count as it stands after the current CHECK cycle. It is computed
  // here so that pass can be decided from the count that includes the final
  // vector.
  always_comb begin
    err_after = err_count;
    if (mismatch) begin
      if (err_count != ERR_MAX) begin
        err_after = err_count + ERR_CNT_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The vector never wraps back to 000 mid-run. After 111
  // is checked the run always ends in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (vec == 3'b111) begin
          state_next = DONE;
        end else begin
          state_next = SETTLE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: the vector, settle counter and result registers. While idle
  // every result is held, so the last run's outcome stays visible until the
  // next start clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec              <= 3'b000;
      settle_cnt       <= '0;
      err_count        <= '0;
      first_fail_vec   <= 3'b000;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec              <= 3'b000;
            settle_cnt       <= '0;
            err_count        <= '0;
            first_fail_vec   <= 3'b000;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + CNT_W'(1);
        end
        CHECK: begin
          err_count <= err_after;
          if (mismatch && !first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
          end
          if (vec == 3'b111) begin
            pass <= (err_after == '0);
          end else begin
            vec        <= vec + 3'd1;
            settle_cnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fa_bist_ctrl
//
// Drives two controllers with different parameter sets. Each one sits in
// front of a behavioural full adder whose outputs can be flipped per vector
// by a fault mask. Expected results come straight from those masks: the
// error count is the number of faulty vectors, and the first failure is the
// lowest faulty vector.
// ---------------------------------------------------------------------------
module tb_fa_bist_ctrl;

  localparam int S0 = 1;
  localparam int W0 = 4;
  localparam int S1 = 3;
  localparam int W1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          start0 = 1'b0;
  logic          a0, b0, c0, sum0, cout0, busy0, done0, pass0, ffvalid0;
  logic [W0-1:0] err0;
  logic [2:0]    ffv0;
  logic [7:0]    sflip0 = 8'h00;
  logic [7:0]    cflip0 = 8'h00;

  logic          start1 = 1'b0;
  logic          a1, b1, c1, sum1, cout1, busy1, done1, pass1, ffvalid1;
  logic [W1-1:0] err1;
  logic [2:0]    ffv1;
  logic [7:0]    sflip1 = 8'h00;
  logic [7:0]    cflip1 = 8'h00;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fa_bist_ctrl #(.SETTLE_CYCLES(S0), .ERR_CNT_W(W0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .a(a0), .b(b0), .c_in(c0),
    .dut_sum(sum0), .dut_c_out(cout0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffvalid0)
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(S1), .ERR_CNT_W(W1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c_in(c1),
    .dut_sum(sum1), .dut_c_out(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
  );

  // Behavioural adders under test: the arithmetic sum of three bits, with
  // optional per-vector output inversion.
  always_comb begin
    int n0;
    n0    = int'(a0) + int'(b0) + int'(c0);
    sum0  = ((n0 % 2) == 1) ^ sflip0[{a0, b0, c0}];
    cout0 = (n0 >= 2) ^ cflip0[{a0, b0, c0}];
  end

  always_comb begin
    int n1;
    n1    = int'(a1) + int'(b1) + int'(c1);
    sum1  = ((n1 % 2) == 1) ^ sflip1[{a1, b1, c1}];
    cout1 = (n1 >= 2) ^ cflip1[{a1, b1, c1}];
  end

  // Mask of vectors on which a stuck-at output differs from the true value.
  function automatic logic [7:0] stuck_mask(input bit is_sum, input bit val);
    logic [7:0] m;
    int n;
    int truth;
    m = 8'h00;
    for (int v = 0; v < 8; v++) begin
      n     = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
      truth = is_sum ? (n % 2) : (n / 2);
      m[v]  = (truth != int'(val));
    end
    return m;
  endfunction

  function automatic logic [2:0] get_vec(input int which);
    return (which == 1) ? {a1, b1, c1} : {a0, b0, c0};
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 1) ? busy1 : busy0;
  endfunction

  function automatic logic get_done(input int which);
    return (which == 1) ? done1 : done0;
  endfunction

  function automatic logic get_pass(input int which);
    return (which == 1) ? pass1 : pass0;
  endfunction

  function automatic logic [31:0] get_err(input int which);
    return (which == 1) ? 32'(err1) : 32'(err0);
  endfunction

  function automatic logic [2:0] get_ffv(input int which);
    return (which == 1) ? ffv1 : ffv0;
  endfunction

  function automatic logic get_ffvalid(input int which);
    return (which == 1) ? ffvalid1 : ffvalid0;
  endfunction

  task automatic set_start(input int which, input logic val);
    if (which == 1) start1 = val;
    else            start0 = val;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input int which, input string tag);
    checkOutput({tag, " vec"},     32'(get_vec(which)),     32'd0);
    checkOutput({tag, " busy"},    32'(get_busy(which)),    32'd0);
    checkOutput({tag, " done"},    32'(get_done(which)),    32'd0);
    checkOutput({tag, " pass"},    32'(get_pass(which)),    32'd0);
    checkOutput({tag, " err"},     get_err(which),          32'd0);
    checkOutput({tag, " ffv"},     32'(get_ffv(which)),     32'd0);
    checkOutput({tag, " ffvalid"}, 32'(get_ffvalid(which)), 32'd0);
  endtask

  // One full run: start is sampled on edge E0, then every edge up to one
  // past the done pulse is checked for vector order, busy and done timing.
  // restart_k >= 0 pulses start again after edge E_restart_k (mid-run).
  task automatic applyStimulus(input int which, input logic [7:0] sf, input logic [7:0] cf,
                               input int restart_k, input string name);
    int s;
    int w;
    int last;
    int max_err;
    int cnt;
    int exp_first;
    logic [7:0] fails;
    s    = (which == 1) ? S1 : S0;
    w    = (which == 1) ? W1 : W0;
    last = 8 * (s + 1);
    if (which == 1) begin
      sflip1 = sf; cflip1 = cf;
    end else begin
      sflip0 = sf; cflip0 = cf;
    end
    fails     = sf | cf;
    cnt       = $countones(fails);
    max_err   = (1 << w) - 1;
    exp_first = 0;
    for (int v = 7; v >= 0; v--) begin
      if (fails[v]) exp_first = v;
    end
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    #1;
    for (int k = 0; k <= last + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      checkOutput($sformatf("%s vec k=%0d", name, k), 32'(get_vec(which)),
                  (k >= last) ? 32'd7 : 32'(k / (s + 1)));
      checkOutput($sformatf("%s busy k=%0d", name, k), 32'(get_busy(which)),
                  (k < last) ? 32'd1 : 32'd0);
      checkOutput($sformatf("%s done k=%0d", name, k), 32'(get_done(which)),
                  (k == last) ? 32'd1 : 32'd0);
      set_start(which, (k == restart_k) ? 1'b1 : 1'b0);
    end
    checkOutput({name, " pass"},    32'(get_pass(which)),    (fails == 8'h00) ? 32'd1 : 32'd0);
    checkOutput({name, " err"},     get_err(which),          32'((cnt > max_err) ? max_err : cnt));
    checkOutput({name, " ffvalid"}, 32'(get_ffvalid(which)), (fails != 8'h00) ? 32'd1 : 32'd0);
    checkOutput({name, " ffv"},     32'(get_ffv(which)),     32'(exp_first));
  endtask

  initial begin
    logic [7:0] rs;
    logic [7:0] rc;
    int which;

    $display("[TB] starting fa_bist_ctrl bench");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(0, "reset0");
    check_reset_state(1, "reset1");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Healthy adder, short settle.
    applyStimulus(0, 8'h00, 8'h00, -1, "good0");
    // Sum stuck at 0: fails on 001, 010, 100, 111.
    applyStimulus(0, stuck_mask(1'b1, 1'b0), 8'h00, -1, "sum_sa0");
    // Carry stuck at 1 on the 2-bit counter: four failures saturate at 3.
    applyStimulus(1, 8'h00, stuck_mask(1'b0, 1'b1), -1, "cout_sa1");
    // Healthy adder, longer settle.
    applyStimulus(1, 8'h00, 8'h00, -1, "good1");

    // Reset in the middle of vector 011's settle cycle.
    sflip0 = stuck_mask(1'b1, 1'b0);
    cflip0 = 8'h00;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst vec before", 32'(get_vec(0)), 32'd3);
    checkOutput("midrst err before", get_err(0),      32'd2);
    rst = 1'b1;
    #1;
    check_reset_state(0, "midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("midrst idle done i=%0d", i), 32'(get_done(0)), 32'd0);
    end
    applyStimulus(0, 8'h00, 8'h00, -1, "after_rst");

    // start pulsed again during vector 101 must be ignored.
    applyStimulus(0, 8'h00, 8'h00, 10, "restart");

    // A failing run followed by a clean one.
    applyStimulus(0, 8'hA5, 8'h10, -1, "fail_then");
    applyStimulus(0, 8'h00, 8'h00, -1, "then_good");

    // Random fault masks on either controller.
    for (int r = 0; r < 6; r++) begin
      which = int'($urandom_range(0, 1));
      rs    = 8'($urandom);
      rc    = 8'($urandom) & 8'($urandom);
      applyStimulus(which, rs, rc, -1, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
